// File: rtl/axi_write_master_pkg.sv
// Shared AXI definitions: response codes, write-master FSM states, AxSIZE helper.
// No logic, no latency; backpressure not applicable.
package axi_write_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wm_state_e;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // AxSIZE encoding is log2 of the bus width in bytes.
    function automatic logic [2:0] axi_size_of(input int bits);
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == bits) return 3'(i);
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// Command, source-data, AXI AW/W/B and completion signals of the write master.
// Pure wiring bundle; master modport is the DUT side, slave the environment side.
interface axi_write_master_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_BITS-1:0]   cmd_addr;
    logic [LEN_BITS-1:0]    cmd_len;

    logic                   src_valid;
    logic                   src_ready;
    logic [DATA_BITS-1:0]   src_data;

    logic                   aw_valid;
    logic                   aw_ready;
    logic [ADDR_BITS-1:0]   aw_addr;
    logic [LEN_BITS-1:0]    aw_len;
    logic [2:0]             aw_size;

    logic                   w_valid;
    logic                   w_ready;
    logic [DATA_BITS-1:0]   w_data;
    logic [DATA_BITS/8-1:0] w_strb;
    logic                   w_last;

    logic                   b_valid;
    logic                   b_ready;
    logic [1:0]             b_resp;

    logic                   done;
    logic [1:0]             done_resp;
    logic [7:0]             err_cnt;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        input  src_valid, src_data,
        output src_ready,
        output aw_valid, aw_addr, aw_len, aw_size,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output done, done_resp, err_cnt
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        output src_valid, src_data,
        input  src_ready,
        input  aw_valid, aw_addr, aw_len, aw_size,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  done, done_resp, err_cnt
    );

endinterface

// File: rtl/axi_skid_buf.sv
// One-entry registered skid buffer for any valid/ready channel.
// Latency 1 cycle; accepts input when empty or when the held entry drains this cycle.
module axi_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_in_vld,
    input  logic [WIDTH-1:0] i_in_dat,
    output logic             o_in_rdy,
    output logic             o_out_vld,
    output logic [WIDTH-1:0] o_out_dat,
    input  logic             i_out_rdy
);

    logic             r_full;
    logic [WIDTH-1:0] r_dat;

    // out_vld is purely the register state, so there is no ready-to-valid path.
    assign o_in_rdy  = !r_full || i_out_rdy;
    assign o_out_vld = r_full;
    assign o_out_dat = r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_dat  <= '0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (i_in_vld && o_in_rdy) begin
            r_full <= 1'b1;
            r_dat  <= i_in_dat;
        end else if (r_full && i_out_rdy) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_write_master.sv
// Single-burst AXI write master: command -> AW -> W beats via skid buffer -> B.
// AW one cycle after command accept; src stalls on W backpressure or once len+1 beats are loaded.
module axi_write_master
    import axi_write_master_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 8
) (
    input  logic               aclk,
    input  logic               areset_n,
    axi_write_master_if.master bus
);

    // One extra bit so a full 2^LEN_BITS burst never wraps the counters.
    localparam int                  CNT_BITS = LEN_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = 1;

    wm_state_e             r_state;
    wm_state_e             w_state_nxt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [LEN_BITS-1:0]   r_len;
    logic [CNT_BITS-1:0]   r_beat_cnt;
    logic [CNT_BITS-1:0]   r_load_cnt;
    logic                  r_done;
    logic [1:0]            r_done_resp;
    logic [7:0]            r_err_cnt;

    logic                  w_cmd_rdy;
    logic                  w_aw_vld;
    logic                  w_b_rdy;
    logic                  w_cmd_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_src_hs;
    logic                  w_load_allow;
    logic                  w_last_beat;
    logic                  w_skid_in_rdy;
    logic                  w_skid_vld;
    logic [DATA_BITS-1:0]  w_skid_dat;

    assign w_last_beat  = (r_beat_cnt == {1'b0, r_len});
    assign w_load_allow = (r_state == ST_DATA) && (r_load_cnt <= {1'b0, r_len});

    assign w_cmd_hs = bus.cmd_valid && w_cmd_rdy;
    assign w_aw_hs  = w_aw_vld && bus.aw_ready;
    assign w_w_hs   = w_skid_vld && bus.w_ready;
    assign w_b_hs   = bus.b_valid && w_b_rdy;
    assign w_src_hs = bus.src_valid && bus.src_ready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // cmd_ready waits out the done cycle and is forced low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_aw_vld    = 1'b0;
        w_b_rdy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_rdy = areset_n && !r_done;
                if (bus.cmd_valid && w_cmd_rdy) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                w_aw_vld = 1'b1;
                if (bus.aw_ready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_w_hs && w_last_beat) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_b_rdy = 1'b1;
                if (bus.b_valid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_load_cnt  <= '0;
            r_done      <= 1'b0;
            r_done_resp <= RESP_OKAY;
            r_err_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_cmd_hs) begin
                r_addr     <= bus.cmd_addr;
                r_len      <= bus.cmd_len;
                r_beat_cnt <= '0;
                r_load_cnt <= '0;
            end
            if (w_src_hs) r_load_cnt <= r_load_cnt + CNT_ONE;
            if (w_w_hs)   r_beat_cnt <= r_beat_cnt + CNT_ONE;
            if (w_b_hs) begin
                r_done      <= 1'b1;
                r_done_resp <= bus.b_resp;
                if ((bus.b_resp != RESP_OKAY) && (r_err_cnt != ERR_CNT_MAX))
                    r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    axi_skid_buf #(
        .WIDTH (DATA_BITS)
    ) u_w_skid (
        .clk       (aclk),
        .rst_n     (areset_n),
        .i_clr     (w_cmd_hs),
        .i_in_vld  (bus.src_valid && w_load_allow),
        .i_in_dat  (bus.src_data),
        .o_in_rdy  (w_skid_in_rdy),
        .o_out_vld (w_skid_vld),
        .o_out_dat (w_skid_dat),
        .i_out_rdy (bus.w_ready)
    );

    assign bus.cmd_ready = w_cmd_rdy;
    assign bus.src_ready = w_load_allow && w_skid_in_rdy;
    assign bus.aw_valid  = w_aw_vld;
    assign bus.aw_addr   = r_addr;
    assign bus.aw_len    = r_len;
    assign bus.aw_size   = axi_size_of(DATA_BITS);
    assign bus.w_valid   = w_skid_vld;
    assign bus.w_data    = w_skid_dat;
    assign bus.w_strb    = '1;
    assign bus.w_last    = (r_state == ST_DATA) && w_last_beat;
    assign bus.b_ready   = w_b_rdy;
    assign bus.done      = r_done;
    assign bus.done_resp = r_done_resp;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: source beats and commands queue expectations,
// the negedge monitor pops and compares them against AW/W/done activity.
module tb_axi_write_master;
    import axi_write_master_pkg::*;

    localparam int DB = 32;
    localparam int AB = 32;
    localparam int LB = 8;

    logic aclk     = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_write_master_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) bus();

    axi_write_master #(.DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [AB+LB-1:0] aw_q[$];
    logic [DB:0]      beat_q[$];
    logic [1:0]       resp_q[$];

    int         w_mode    = 0;
    bit         src_rand  = 0;
    bit         src_en    = 0;
    bit         b_en      = 0;
    bit         mon_en    = 0;
    int         aw_stall  = 0;
    int         aw_wait   = 0;
    int         cur_len   = 0;
    logic [1:0] cur_resp  = RESP_OKAY;
    logic [31:0] data_base = 32'h0;

    int   src_cnt = 0, w_cnt = 0, done_cnt = 0, model_err = 0;
    bit   aw_seen = 0, last_seen = 0, prev_w_stall = 0, prev_aw_stall = 0;
    logic [DB-1:0]    prev_w_data = '0;
    logic [AB+LB-1:0] prev_aw = '0;

    // Environment drivers: update one time unit after each rising edge.
    always @(posedge aclk) begin
        #1;
        if (src_en) begin
            bus.src_valid = src_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.src_data  = data_base + 32'(src_cnt);
        end else begin
            bus.src_valid = 1'b0;
        end
        case (w_mode)
            0:       bus.w_ready = 1'b1;
            1:       bus.w_ready = ~bus.w_ready;
            default: bus.w_ready = ($urandom_range(0, 3) != 0);
        endcase
        bus.aw_ready = (aw_wait >= aw_stall);
        bus.b_valid  = b_en;
        bus.b_resp   = cur_resp;
    end

    // Monitor at the falling edge: each handshake seen here completes on the next rising edge.
    always @(negedge aclk) begin
        if (areset_n && mon_en) begin
            if (bus.src_valid && bus.src_ready) begin
                beat_q.push_back({(src_cnt == cur_len), data_base + 32'(src_cnt)});
                src_cnt++;
            end
            if (prev_aw_stall)
                check_eq("aw_hold", 64'({bus.aw_valid, bus.aw_addr, bus.aw_len}), 64'({1'b1, prev_aw}));
            prev_aw_stall = 0;
            if (bus.aw_valid) begin
                if (bus.aw_ready) begin
                    check_eq("aw_size", 64'(bus.aw_size), 64'd2);
                    if (aw_q.size() == 0) check_eq("aw_unexpected", 64'(aw_q.size()), 64'd1);
                    else check_eq("aw_addr_len", 64'({bus.aw_addr, bus.aw_len}), 64'(aw_q.pop_front()));
                    aw_seen = 1;
                end else begin
                    prev_aw_stall = 1;
                    prev_aw = {bus.aw_addr, bus.aw_len};
                    aw_wait++;
                end
            end
            if (prev_w_stall)
                check_eq("w_hold", 64'({bus.w_valid, bus.w_data}), 64'({1'b1, prev_w_data}));
            prev_w_stall = 0;
            if (bus.w_valid) begin
                check_eq("w_after_aw", 64'(aw_seen), 64'd1);
                check_eq("w_strb", 64'(bus.w_strb), 64'hF);
                if (bus.w_ready) begin
                    if (beat_q.size() == 0) check_eq("w_unexpected", 64'(beat_q.size()), 64'd1);
                    else check_eq("w_beat", 64'({bus.w_last, bus.w_data}), 64'(beat_q.pop_front()));
                    w_cnt++;
                    if (bus.w_last) last_seen = 1;
                end else begin
                    prev_w_stall = 1;
                    prev_w_data  = bus.w_data;
                end
            end
            if (bus.b_valid && !last_seen)
                check_eq("b_early", 64'(bus.b_ready), 64'd0);
            if (bus.done) begin
                check_eq("cmd_rdy_in_done", 64'(bus.cmd_ready), 64'd0);
                if (resp_q.size() == 0) check_eq("done_unexpected", 64'(resp_q.size()), 64'd1);
                else begin
                    logic [1:0] r;
                    r = resp_q.pop_front();
                    check_eq("done_resp", 64'(bus.done_resp), 64'(r));
                    if (r != RESP_OKAY && model_err < 255) model_err++;
                end
                check_eq("err_cnt", 64'(bus.err_cnt), 64'(model_err));
                done_cnt++;
            end
        end
    end

    task automatic clear_burst();
        src_cnt = 0; w_cnt = 0; done_cnt = 0; aw_wait = 0;
        aw_seen = 0; last_seen = 0; prev_w_stall = 0; prev_aw_stall = 0;
        aw_q.delete(); beat_q.delete(); resp_q.delete();
    endtask

    task automatic start_cmd(input logic [31:0] addr, input int len, input logic [1:0] resp,
                             input int wm, input bit srand, input int stall);
        bit got;
        clear_burst();
        cur_len = len; cur_resp = resp; w_mode = wm; src_rand = srand; aw_stall = stall;
        data_base = $urandom;
        aw_q.push_back({addr, LB'(len)});
        resp_q.push_back(resp);
        src_en = 1; b_en = 1;
        @(posedge aclk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_len = LB'(len);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.cmd_ready) begin got = 1; break; end
        end
        check_eq("cmd_accept", 64'(got), 64'd1);
        @(posedge aclk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge aclk);
        check_eq("aw_latency", 64'(bus.aw_valid), 64'd1);
    endtask

    task automatic wait_done(input int len);
        for (int i = 0; i < 4000; i++) begin
            @(posedge aclk);
            if (done_cnt != 0) break;
        end
        src_en = 0; b_en = 0;
        @(negedge aclk); @(negedge aclk);
        check_eq("done_count", 64'(done_cnt), 64'd1);
        check_eq("src_beats", 64'(src_cnt), 64'(len + 1));
        check_eq("w_beats", 64'(w_cnt), 64'(len + 1));
        check_eq("beat_q_left", 64'(beat_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.src_valid = 1'b0; bus.src_data = '0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = '0;
        #1;
        check_eq("rst_valids", 64'({bus.cmd_ready, bus.src_ready, bus.aw_valid, bus.w_valid, bus.b_ready}), 64'd0);
        check_eq("rst_done", 64'({bus.done, bus.done_resp, bus.err_cnt}), 64'd0);
        repeat (3) @(posedge aclk);
        @(negedge aclk); areset_n = 1'b1; mon_en = 1;
        @(negedge aclk);
        check_eq("cmd_rdy_after_rst", 64'(bus.cmd_ready), 64'd1);

        start_cmd(32'h100, 3, RESP_OKAY, 0, 0, 0);   wait_done(3);
        start_cmd(32'h2000, 0, RESP_OKAY, 1, 0, 0);  wait_done(0);
        start_cmd(32'h3000, 2, RESP_OKAY, 0, 0, 5);  wait_done(2);
        for (int k = 0; k < 3; k++) begin
            start_cmd(32'h4000 + 32'(k * 16), 1, RESP_SLVERR, 2, 1, 0); wait_done(1);
        end
        check_eq("err_after_3", 64'(bus.err_cnt), 64'd3);
        check_eq("resp_after_3", 64'(bus.done_resp), 64'(RESP_SLVERR));
        for (int k = 0; k < 297; k++) begin
            start_cmd(32'h5000, 0, (k % 2 == 0) ? RESP_DECERR : RESP_SLVERR, 0, 0, 0); wait_done(0);
        end
        start_cmd(32'h6000, 0, RESP_EXOKAY, 0, 0, 0); wait_done(0);
        check_eq("err_saturated", 64'(bus.err_cnt), 64'd255);

        // Reset during the second beat of an 8-beat burst.
        start_cmd(32'h7000, 7, RESP_OKAY, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            @(posedge aclk);
            if (w_cnt >= 1) break;
        end
        #3; mon_en = 0; areset_n = 1'b0;
        #1;
        check_eq("mid_rst_valids", 64'({bus.cmd_ready, bus.src_ready, bus.aw_valid, bus.w_valid, bus.b_ready}), 64'd0);
        check_eq("mid_rst_done", 64'({bus.done, bus.err_cnt}), 64'd0);
        model_err = 0; src_en = 0; b_en = 0;
        clear_burst();
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        check_eq("post_rst_done", 64'({bus.done, bus.done_resp}), 64'd0);
        mon_en = 1;
        start_cmd(32'h7000, 7, RESP_OKAY, 2, 1, 0);  wait_done(7);

        start_cmd(32'h8000, 255, RESP_OKAY, 2, 1, 2); wait_done(255);
        check_eq("err_final", 64'(bus.err_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
